// File: rtl/mppt_po_controller.sv
// -----------------------------------------------------------------------------
// mppt_po_controller
//
// Perturb-and-observe maximum power point tracker. Each accepted (v, i) sample
// passes through a fixed four-state sequence:
//   IDLE   : wait for a sample, capture v/i/step/deadband on accept
//   MULT   : P = v * i at full 2*DATA_W width
//   DECIDE : dP = P - P_prev, dV = v - v_prev (signed, one extra bit)
//   UPDATE : pick direction, apply the deadband, step and clamp the duty.
//            Store P_prev/v_prev and pulse duty_valid.
// The first sample after reset only primes P_prev/v_prev.
//
// Optional feature macro: MPPT_ADAPTIVE_STEP_EN
//   When defined, the step doubles (saturating at 2^STEP_W-1) whenever
//   |dP| > deadband*8. When undefined, no adaptive hardware is built.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       gates acceptance of new samples
//   sample_valid v_in/i_in are valid
//   sample_ready block can take a sample (IDLE && enable)
//   v_in, i_in   unsigned voltage / current samples (DATA_W)
//   step_size    unsigned duty perturbation step (STEP_W)
//   deadband     unsigned |dP| hold threshold (2*DATA_W)
//   duty_out     current duty command (DUTY_W)
//   duty_valid   one-cycle pulse on each duty update
//   at_limit     last update was clamped
//   dir_up       direction of the last nonzero perturbation
// -----------------------------------------------------------------------------
module mppt_po_controller #(
  parameter int DATA_W    = 16,
  parameter int DUTY_W    = 8,
  parameter int STEP_W    = 4,
  parameter int DUTY_MIN  = 8,
  parameter int DUTY_MAX  = 247,
  parameter int DUTY_INIT = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic [DATA_W-1:0]     v_in,
  input  logic [DATA_W-1:0]     i_in,
  input  logic [STEP_W-1:0]     step_size,
  input  logic [2*DATA_W-1:0]   deadband,
  output logic [DUTY_W-1:0]     duty_out,
  output logic                  duty_valid,
  output logic                  at_limit,
  output logic                  dir_up
);

  localparam int PW = 2 * DATA_W;   // power width
  localparam int DW = PW + 1;       // signed power-difference width
  localparam int SW = DUTY_W + 2;   // signed duty arithmetic width

  localparam logic signed [SW-1:0] DUTY_MAX_S = SW'(DUTY_MAX);
  localparam logic signed [SW-1:0] DUTY_MIN_S = SW'(DUTY_MIN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    DECIDE = 2'd2,
    UPDATE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Captured sample and pipeline registers
  logic [DATA_W-1:0]        v_reg, i_reg, v_prev_reg;
  logic [STEP_W-1:0]        step_reg;
  logic [PW-1:0]            deadband_reg;
  logic [PW-1:0]            p_reg, p_prev_reg;
  logic signed [DW-1:0]     dp_reg;
  logic signed [DATA_W:0]   dv_reg;
  logic                     primed_reg;

  // Output registers
  logic [DUTY_W-1:0]        duty_reg;
  logic                     duty_valid_reg;
  logic                     at_limit_reg;
  logic                     dir_up_reg;

  logic accept;

  assign sample_ready = (state_reg == IDLE) && enable;
  assign accept       = sample_valid && sample_ready;

  assign duty_out   = duty_reg;
  assign duty_valid = duty_valid_reg;
  assign at_limit   = at_limit_reg;
  assign dir_up     = dir_up_reg;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = MULT;
      MULT:    state_next = DECIDE;
      DECIDE:  state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // UPDATE-stage combinational decision
  // ---------------------------------------------------------------------------
  logic [DW-1:0]          abs_dp;
  logic                   hold;
  logic                   dp_pos, dp_neg, dv_pos;
  logic                   go_up;
  logic [STEP_W-1:0]      step_eff;
  logic signed [SW-1:0]   duty_ext, step_ext, sum;
  logic [DUTY_W-1:0]      duty_clamped;
  logic                   clamp_hit;
  logic                   moving;

`ifdef MPPT_ADAPTIVE_STEP_EN
  logic                   big_change;
  logic [STEP_W:0]        step_doubled;
`endif

  always_comb begin
    abs_dp = dp_reg[DW-1] ? DW'(-dp_reg) : DW'(dp_reg);
    hold   = (abs_dp <= {1'b0, deadband_reg});

    dp_pos = !dp_reg[DW-1] && (|dp_reg);
    dp_neg = dp_reg[DW-1];
    dv_pos = !dv_reg[DATA_W] && (|dv_reg);
    // dV == 0 counts as "not greater", so a power drop at constant voltage
    // moves the duty up.
    go_up  = (dp_pos && dv_pos) || (dp_neg && !dv_pos);

`ifdef MPPT_ADAPTIVE_STEP_EN
    big_change   = ({2'b00, abs_dp} > {deadband_reg, 3'b000});
    step_doubled = {step_reg, 1'b0};
    if (big_change) begin
      step_eff = (step_doubled > {1'b0, {STEP_W{1'b1}}}) ? {STEP_W{1'b1}}
                                                          : step_doubled[STEP_W-1:0];
    end else begin
      step_eff = step_reg;
    end
`else
    step_eff = step_reg;
`endif

    moving   = !hold && (step_eff != '0);

    // Two extra bits let the sum overshoot either rail without wrapping.
    duty_ext = $signed({2'b00, duty_reg});
    step_ext = $signed(SW'(step_eff));
    sum      = go_up ? (duty_ext + step_ext) : (duty_ext - step_ext);

    duty_clamped = sum[DUTY_W-1:0];
    clamp_hit    = 1'b0;
    if (sum > DUTY_MAX_S) begin
      duty_clamped = DUTY_W'(DUTY_MAX);
      clamp_hit    = 1'b1;
    end else if (sum < DUTY_MIN_S) begin
      duty_clamped = DUTY_W'(DUTY_MIN);
      clamp_hit    = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_reg          <= '0;
      i_reg          <= '0;
      step_reg       <= '0;
      deadband_reg   <= '0;
      p_reg          <= '0;
      dp_reg         <= '0;
      dv_reg         <= '0;
      p_prev_reg     <= '0;
      v_prev_reg     <= '0;
      primed_reg     <= 1'b0;
      duty_reg       <= DUTY_W'(DUTY_INIT);
      duty_valid_reg <= 1'b0;
      at_limit_reg   <= 1'b0;
      dir_up_reg     <= 1'b1;
    end else begin
      duty_valid_reg <= 1'b0;

      if (accept) begin
        v_reg        <= v_in;
        i_reg        <= i_in;
        step_reg     <= step_size;
        deadband_reg <= deadband;
      end

      if (state_reg == MULT) begin
        p_reg <= PW'(v_reg) * PW'(i_reg);
      end

      if (state_reg == DECIDE) begin
        dp_reg <= $signed({1'b0, p_reg}) - $signed({1'b0, p_prev_reg});
        dv_reg <= $signed({1'b0, v_reg}) - $signed({1'b0, v_prev_reg});
      end

      if (state_reg == UPDATE) begin
        p_prev_reg <= p_reg;
        v_prev_reg <= v_reg;
        primed_reg <= 1'b1;
        // The priming sample has no valid history to compare against.
        if (primed_reg) begin
          duty_valid_reg <= 1'b1;
          if (moving) begin
            duty_reg     <= duty_clamped;
            at_limit_reg <= clamp_hit;
            dir_up_reg   <= go_up;
          end else begin
            at_limit_reg <= 1'b0;
          end
        end
      end
    end
  end

endmodule
